cart_rom_port: RTL and testbench

CART_ROM_PORT -- requirements
Module: cart_rom_port

---
 rtl/cart_rom_port.sv | 198 +++++++++++++++++++
 tb/tb_cart_rom_port.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_port.sv
// Cartridge ROM port: serves console byte reads from 16-bit word memory through a one-word
// hit buffer, and packs ROM download bytes into word writes.
module cart_rom_port #(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cart_read,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_out,
  output logic              cart_valid,
  input  logic              loading,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              overrun
);

  localparam int unsigned WordW = ADDR_W - 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e            state_q;
  logic [7:0]        cart_out_q;
  logic              cart_valid_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [WordW-1:0]  mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              overrun_q;
  logic              rd_hi_q;
  logic              hb_v_q;
  logic [WordW-1:0]  hb_addr_q;
  logic [15:0]       hb_data_q;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              wslot_v_q;
  logic [WordW-1:0]  wslot_addr_q;
  logic [15:0]       wslot_data_q;
  logic [7:0]        lo_byte_q;
  logic              loading_q;

  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  logic             idle;
  logic             new_rd;
  logic             ld_odd;
  logic [WordW-1:0] ld_word;
  logic [15:0]      ld_word_data;
  logic             wr_from_slot;
  logic             wr_direct;
  logic             do_wr;
  logic [WordW-1:0] wr_word;
  logic [15:0]      wr_data;
  logic             rd_src_pend;
  logic             rd_src_new;
  logic [WordW-1:0] rd_word;
  logic             rd_hi;
  logic             rd_hit;
  logic             serve_hit;
  logic             issue_rd;
  logic             pend_take;
  logic             new_taken;
  logic             latch_new;
  logic             load_rise;

  assign idle         = (state_q == StIdle);
  assign new_rd       = cart_read & ~loading;
  assign ld_odd       = ld_wr & ld_addr[0];
  assign ld_word      = ld_addr[ADDR_W-1:1];
  assign ld_word_data = {ld_data, lo_byte_q};
  assign load_rise    = loading & ~loading_q;

  // Queued write beats a fresh download write, and any write beats a read.
  assign wr_from_slot = idle & wslot_v_q;
  assign wr_direct    = idle & ~wslot_v_q & ld_odd;
  assign do_wr        = wr_from_slot | wr_direct;
  assign wr_word      = wslot_v_q ? wslot_addr_q : ld_word;
  assign wr_data      = wslot_v_q ? wslot_data_q : ld_word_data;

  assign rd_src_pend  = idle & ~do_wr & pend_v_q;
  assign rd_src_new   = idle & ~do_wr & ~pend_v_q & new_rd;
  assign rd_word      = pend_v_q ? pend_addr_q[ADDR_W-1:1] : cart_addr[ADDR_W-1:1];
  assign rd_hi        = pend_v_q ? pend_addr_q[0] : cart_addr[0];
  assign rd_hit       = hb_v_q & (rd_word == hb_addr_q);

  // A hit is held back one cycle when cart_valid is already high, so pulses never touch.
  assign serve_hit    = (rd_src_pend | rd_src_new) & rd_hit & ~cart_valid_q;
  assign issue_rd     = (rd_src_pend | rd_src_new) & ~rd_hit;
  assign pend_take    = rd_src_pend & (serve_hit | issue_rd);
  assign new_taken    = rd_src_new & (serve_hit | issue_rd);
  assign latch_new    = new_rd & ~new_taken;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      cart_out_q   <= 8'h00;
      cart_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 16'h0000;
      overrun_q    <= 1'b0;
      rd_hi_q      <= 1'b0;
      hb_v_q       <= 1'b0;
      hb_addr_q    <= '0;
      hb_data_q    <= 16'h0000;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      wslot_v_q    <= 1'b0;
      wslot_addr_q <= '0;
      wslot_data_q <= 16'h0000;
      lo_byte_q    <= 8'h00;
      loading_q    <= 1'b0;
    end else begin
      cart_valid_q <= 1'b0;
      loading_q    <= loading;

      if (ld_wr && !ld_addr[0]) lo_byte_q <= ld_data;

      if (ld_odd && !wr_direct) begin
        wslot_v_q    <= 1'b1;
        wslot_addr_q <= ld_word;
        wslot_data_q <= ld_word_data;
      end else if (wr_from_slot) begin
        wslot_v_q <= 1'b0;
      end

      if (latch_new) begin
        pend_v_q    <= 1'b1;
        pend_addr_q <= cart_addr;
        if (pend_v_q && !pend_take) overrun_q <= 1'b1;
      end else if (pend_take) begin
        pend_v_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (do_wr) begin
            state_q     <= StWrWait;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_word;
            mem_wdata_q <= wr_data;
            if (wr_word == hb_addr_q) hb_v_q <= 1'b0;
          end else if (issue_rd) begin
            state_q    <= StRdWait;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= rd_word;
            rd_hi_q    <= rd_hi;
          end else if (serve_hit) begin
            cart_out_q   <= sel_byte(hb_data_q, rd_hi);
            cart_valid_q <= 1'b1;
          end
        end
        StRdWait: begin
          if (mem_ack) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            cart_out_q   <= sel_byte(mem_rdata, rd_hi_q);
            cart_valid_q <= 1'b1;
            hb_data_q    <= mem_rdata;
            hb_addr_q    <= mem_addr_q;
            hb_v_q       <= 1'b1;
          end
        end
        StWrWait: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new download makes the buffered word stale regardless of what else happens.
      if (load_rise) hb_v_q <= 1'b0;
    end
  end

  assign cart_out   = cart_out_q;
  assign cart_valid = cart_valid_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cart_rom_port.sv
// Bench for cart_rom_port: directed scenarios plus randomized reads/downloads checked against
// a byte-image model of the cartridge ROM, with a word memory responder of variable latency.
module tb_cart_rom_port;

  localparam int unsigned AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          cart_read;
  logic [AW-1:0] cart_addr;
  logic [7:0]    cart_out;
  logic          cart_valid;
  logic          loading;
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = 16'h0000;
  logic          overrun;

  always #5 clk_sys = ~clk_sys;

  cart_rom_port #(.ADDR_W(AW)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cart_read (cart_read),
    .cart_addr (cart_addr),
    .cart_out  (cart_out),
    .cart_valid(cart_valid),
    .loading   (loading),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .overrun   (overrun)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Reference: the ROM as a flat byte image, updated whenever the bench downloads a byte.
  logic [7:0] img [0:511];

  // Word memory responder.
  logic [15:0] mem_arr [0:255];
  int          lat = 1;
  int          rsp_cnt = 0;
  logic        req_seen = 1'b0;
  logic        cap_we = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [15:0] cap_wdata = '0;

  always @(posedge clk_sys) begin
    mem_ack <= 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt <= rsp_cnt - 1;
      if (rsp_cnt == 1) begin
        mem_ack <= 1'b1;
        if (cap_we) mem_arr[cap_addr[7:0]] <= cap_wdata;
        else        mem_rdata <= mem_arr[cap_addr[7:0]];
      end
    end else if (mem_req && !req_seen) begin
      rsp_cnt   <= lat;
      req_seen  <= 1'b1;
      cap_we    <= mem_we;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
    end
    if (!mem_req) req_seen <= 1'b0;
  end

  // Monitor, sampled mid-cycle.
  logic [7:0]  got_q [$];
  logic [23:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int   rd_req_cnt = 0;
  int   valid_cyc = 0;
  int   ack_cyc = 0;
  int   viol_valid = 0;
  int   viol_req = 0;
  logic prev_valid = 1'b0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_we = 1'b0;
  logic [23:0] prev_addr = '0;

  always @(negedge clk_sys) begin
    if (cart_valid) begin
      got_q.push_back(cart_out);
      valid_cyc = cyc;
      if (prev_valid) viol_valid++;
    end
    if (mem_ack) ack_cyc = cyc;
    if (mem_req && !prev_req) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        rd_req_cnt++;
      end
    end
    if (prev_ack && mem_req) viol_req++;
    if (prev_req && mem_req && !prev_ack && (mem_addr != prev_addr || mem_we != prev_we))
      viol_req++;
    prev_valid = cart_valid;
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((mem_req || rsp_cnt != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("mem_quiet_timeout", 32'(mem_req), 32'd0);
  endtask

  task automatic ld_byte(input int a, input logic [7:0] d);
    ld_wr   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_wr = 1'b0;
    img[a] = d;
    if (a % 2 == 1) wait_quiet();
  endtask

  int strobe_cyc = 0;
  task automatic strobe(input int a);
    cart_read  = 1'b1;
    cart_addr  = AW'(a);
    strobe_cyc = cyc;
    tick();
    cart_read = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] b);
    int n0 = got_q.size();
    int n = 0;
    strobe(a);
    while (got_q.size() <= n0 && n < 60) begin
      tick();
      n++;
    end
    if (got_q.size() <= n0) begin
      chk("rd_timeout", 32'(got_q.size()), 32'(n0 + 1));
      b = 8'hxx;
    end else begin
      b = got_q[n0];
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cart_out"}, 32'(cart_out), 32'h00);
    chk({tag, "_cart_valid"}, 32'(cart_valid), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int r0;
    int v0;
    int a;
    int a2;
    int w;
    int n;

    reset = 1'b1; cart_read = 1'b0; cart_addr = '0; loading = 1'b0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = 8'h00;
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Download a random image; word 0x10 holds 0x1234.
    loading = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      if (i % 2 == 0) lat = $urandom_range(1, 6);
      if (i == 'h20)      ld_byte(i, 8'h34);
      else if (i == 'h21) ld_byte(i, 8'h12);
      else                ld_byte(i, 8'($urandom));
    end

    // Download pair packs into one word write.
    wr_addr_q.delete();
    wr_data_q.delete();
    lat = 2;
    ld_byte('h100, 8'hAA);
    chk("pair_even_no_write", 32'(wr_addr_q.size()), 32'd0);
    ld_byte('h101, 8'h55);
    chk("pair_write_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() >= 1) begin
      chk("pair_mem_addr", 32'(wr_addr_q[0]), 32'h80);
      chk("pair_mem_wdata", 32'(wr_data_q[0]), 32'h55AA);
    end
    loading = 1'b0;
    tick();

    // Miss then hit.
    lat = 3;
    r0 = rd_req_cnt;
    rd('h21, b);
    chk("miss_data", 32'(b), 32'h12);
    chk("miss_req", 32'(rd_req_cnt - r0), 32'd1);
    chk("miss_valid_after_ack", 32'(valid_cyc - ack_cyc), 32'd1);
    repeat (2) tick();
    r0 = rd_req_cnt;
    rd('h20, b);
    chk("hit_data", 32'(b), 32'h34);
    chk("hit_no_req", 32'(rd_req_cnt - r0), 32'd0);
    chk("hit_latency", 32'(valid_cyc - strobe_cyc), 32'd1);
    repeat (2) tick();
    rd('h100, b);
    chk("pair_readback", 32'(b), 32'hAA);
    repeat (2) tick();

    // Three strobes during a slow miss: the middle one is overwritten.
    lat = 6;
    chk("overrun_clear", 32'(overrun), 32'd0);
    v0 = got_q.size();
    strobe('h80);
    tick();
    strobe('h93);
    tick();
    strobe('h81);
    repeat (40) tick();
    chk("busy_valid_count", 32'(got_q.size() - v0), 32'd2);
    if (got_q.size() >= v0 + 2) begin
      chk("busy_first", 32'(got_q[v0]), 32'(img['h80]));
      chk("busy_third", 32'(got_q[v0 + 1]), 32'(img['h81]));
    end
    chk("busy_overrun", 32'(overrun), 32'd1);

    // Invalidation by download.
    lat = 2;
    rd('h100, b);
    chk("inv_prime", 32'(b), 32'(img['h100]));
    repeat (2) tick();
    r0 = rd_req_cnt;
    rd('h101, b);
    chk("inv_buffer_hit", 32'(rd_req_cnt - r0), 32'd0);
    loading = 1'b1;
    tick();
    v0 = got_q.size();
    strobe('h10);
    repeat (5) tick();
    chk("read_ignored_loading", 32'(got_q.size() - v0), 32'd0);
    ld_byte('h100, 8'h11);
    ld_byte('h101, 8'h22);
    loading = 1'b0;
    tick();
    r0 = rd_req_cnt;
    rd('h100, b);
    chk("inv_refetch_req", 32'(rd_req_cnt - r0), 32'd1);
    chk("inv_refetch_data", 32'(b), 32'h11);
    repeat (2) tick();

    // Reset while a read is outstanding; the late ack must be ignored.
    lat = 6;
    v0 = got_q.size();
    strobe('h40);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("rst_mid_no_valid", 32'(got_q.size() - v0), 32'd0);
    chk_reset_outputs("rst_mid");
    rd('h40, b);
    chk("rst_recover", 32'(b), 32'(img['h40]));
    repeat (2) tick();

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      lat = $urandom_range(1, 6);
      n = $urandom_range(0, 5);
      if (n == 0) begin
        loading = 1'b1;
        tick();
        w = $urandom_range(0, 255);
        ld_byte(2 * w, 8'($urandom));
        ld_byte(2 * w + 1, 8'($urandom));
        loading = 1'b0;
        tick();
      end else if (n == 1) begin
        a  = $urandom_range(0, 511);
        a2 = ($urandom_range(0, 1) == 0) ? (a ^ 1) : $urandom_range(0, 511);
        v0 = got_q.size();
        strobe(a);
        strobe(a2);
        w = 0;
        while (got_q.size() < v0 + 2 && w < 80) begin
          tick();
          w++;
        end
        chk("rnd_pair_count", 32'(got_q.size() - v0), 32'd2);
        if (got_q.size() >= v0 + 2) begin
          chk("rnd_pair_first", 32'(got_q[v0]), 32'(img[a]));
          chk("rnd_pair_second", 32'(got_q[v0 + 1]), 32'(img[a2]));
        end
      end else begin
        a = $urandom_range(0, 511);
        rd(a, b);
        chk("rnd_read", 32'(b), 32'(img[a]));
      end
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (10) tick();
    chk("no_back_to_back_valid", 32'(viol_valid), 32'd0);
    chk("mem_req_protocol", 32'(viol_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
